// File: rtl/fast_pkg.sv
// Shared constants and types for the FAST corner pipeline.
// Latency: none (package only).
// Backpressure: none (package only).
package fast_pkg;

  localparam int PIX_W  = 8;
  localparam int N_CIRC = 16;
  localparam int RADIUS = 3;

  typedef logic [PIX_W-1:0] pix_t;

  // Radius-3 Bresenham circle, clockwise from 12 o'clock. Index order is
  // what the contiguity test in the detector relies on.
  localparam int CIRC_DX [0:N_CIRC-1] = '{ 0,  1,  2,  3,  3,  3,  2,  1,
                                           0, -1, -2, -3, -3, -3, -2, -1};
  localparam int CIRC_DY [0:N_CIRC-1] = '{-3, -3, -2, -1,  0,  1,  2,  3,
                                           3,  3,  2,  1,  0, -1, -2, -3};

endpackage

// File: rtl/line_store.sv
// Simple dual-port RAM holding the six previous image lines per column.
// Latency: one cycle synchronous read; the write lands on the clock edge.
// Backpressure: none; read data holds while i_re is low.
//
// Ports: i_clk; read port i_re/i_raddr/o_rdat; write port i_we/i_waddr/i_wdat.
module line_store #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int DW    = 48
) (
  input  logic          i_clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat
);

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdat;
    end
    if (i_re) begin
      o_rdat <= mem[i_raddr];
    end
  end

endmodule

// File: rtl/fast_circle_window.sv
// 7x7 streaming window producing the centre pixel and its 16 circle taps.
// Latency: a pixel accepted in cycle N yields its window o_v in cycle N+2.
// Backpressure: none; i_v low freezes the pipeline, outputs hold.
//
// Ports: i_clk, i_rst (sync, active high); input stream i_pix/i_v/i_sof;
// output window o_crc[0:15]/o_ctr at centre (o_x,o_y), qualified by o_v.
module fast_circle_window
  import fast_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  pix_t          i_pix,
  input  logic          i_v,
  input  logic          i_sof,
  output pix_t          o_crc [0:N_CIRC-1],
  output pix_t          o_ctr,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_v
);

  localparam int WIN = 2 * RADIUS + 1;
  localparam int LW  = PIX_W * (WIN - 1);

  // Position counters
  logic [XW-1:0] x, cur_x, nxt_x;
  logic [YW-1:0] y, cur_y, nxt_y;
  logic          win_ok;

  // i_sof relabels the current pixel as (0,0) before anything else uses it.
  always_comb begin
    cur_x  = i_sof ? '0 : x;
    cur_y  = i_sof ? '0 : y;
    nxt_x  = cur_x + XW'(1);
    nxt_y  = cur_y;
    if (cur_x == XW'(IMG_W - 1)) begin
      nxt_x = '0;
      nxt_y = (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + YW'(1);
    end
    win_ok = (cur_x >= XW'(2 * RADIUS)) && (cur_y >= YW'(2 * RADIUS));
  end

  // Stage 1: pixel and position travel alongside the RAM read
  logic          s1_v;
  logic          s1_ok;
  pix_t          s1_pix;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x     <= '0;
      y     <= '0;
      s1_v  <= 1'b0;
      s1_ok <= 1'b0;
    end else begin
      s1_v <= i_v;
      if (i_v) begin
        x     <= nxt_x;
        y     <= nxt_y;
        s1_ok <= win_ok;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_v) begin
      s1_pix <= i_pix;
      s1_x   <= cur_x;
      s1_y   <= cur_y;
    end
  end

  // Line store: word bits [8k-1:8k-8] hold row y-k for k = 1..6
  logic [LW-1:0] rd_dat;
  logic [LW-1:0] wr_dat;

  assign wr_dat = {rd_dat[LW-PIX_W-1:0], s1_pix};

  line_store #(
    .DEPTH (IMG_W),
    .AW    (XW),
    .DW    (LW)
  ) u_line_store (
    .i_clk   (i_clk),
    .i_re    (i_v),
    .i_raddr (cur_x),
    .o_rdat  (rd_dat),
    .i_we    (s1_v),
    .i_waddr (s1_x),
    .i_wdat  (wr_dat)
  );

  // Window: win[col][row], column 6 newest (x), row 6 newest (y)
  pix_t win  [0:WIN-1][0:WIN-1];
  pix_t nwin [0:WIN-1][0:WIN-1];

  always_comb begin
    nwin = win;
    for (int c = 0; c < WIN - 1; c++) begin
      for (int r = 0; r < WIN; r++) begin
        nwin[c][r] = win[c+1][r];
      end
    end
    nwin[WIN-1][WIN-1] = s1_pix;
    for (int k = 1; k < WIN; k++) begin
      nwin[WIN-1][WIN-1-k] = rd_dat[PIX_W*k-1 -: PIX_W];
    end
  end

  // Stale columns from the previous line are never seen: win_ok needs
  // seven shifts within the current line before any window is emitted.
  always_ff @(posedge i_clk) begin
    if (s1_v) begin
      win <= nwin;
    end
  end

  // Taps are taken from the post-shift window so the output register is
  // the only stage after the RAM read.
  pix_t tap [0:N_CIRC-1];

  for (genvar gi = 0; gi < N_CIRC; gi++) begin : g_tap
    localparam int TC = RADIUS + CIRC_DX[gi];
    localparam int TR = RADIUS + CIRC_DY[gi];
    assign tap[gi] = nwin[TC][TR];
  end

  // Output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_v   <= 1'b0;
      o_ctr <= '0;
      o_x   <= '0;
      o_y   <= '0;
      for (int i = 0; i < N_CIRC; i++) begin
        o_crc[i] <= '0;
      end
    end else begin
      o_v <= s1_v && s1_ok;
      if (s1_v && s1_ok) begin
        o_ctr <= nwin[RADIUS][RADIUS];
        o_x   <= s1_x - XW'(RADIUS);
        o_y   <= s1_y - YW'(RADIUS);
        for (int i = 0; i < N_CIRC; i++) begin
          o_crc[i] <= tap[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_fast_circle_window.sv
// Directed bench for fast_circle_window on a 16x12 ramp image.
// Latency: checks the two-cycle accept-to-o_v delay on every window.
// Backpressure: exercises random i_v gaps; the DUT has no ready signal.
module tb_fast_circle_window;

  localparam int W = 16;
  localparam int H = 12;

  typedef struct packed {
    logic [3:0]       x;
    logic [3:0]       y;
    logic [7:0]       ctr;
    logic [15:0][7:0] crc;
  } win_t;

  typedef struct {
    int idx;
    int ex, ey, ectr;
    int c0, c4, c8, c12, c2;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix;
  logic       v;
  logic       sof;
  logic [7:0] crc [0:15];
  logic [7:0] ctr;
  logic [3:0] ox;
  logic [3:0] oy;
  logic       ov;

  always #5 clk = ~clk;

  fast_circle_window #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_pix (pix),
    .i_v   (v),
    .i_sof (sof),
    .o_crc (crc),
    .o_ctr (ctr),
    .o_x   (ox),
    .o_y   (oy),
    .o_v   (ov)
  );

  int tdx [0:15] = '{ 0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3, -3, -3, -2, -1};
  int tdy [0:15] = '{-3, -3, -2, -1,  0,  1,  2,  3,  3,  3,  2,  1,  0, -1, -2, -3};

  int   n_chk  = 0;
  int   n_fail = 0;
  int   edges  = 0;
  win_t cap_q [$];
  int   cap_e [$];
  win_t exp_q [$];
  int   exp_e [$];
  win_t ref_q [$];
  win_t mon_w;
  vec_t tbl [4];

  always @(posedge clk) edges++;

  always @(negedge clk) begin
    if (ov === 1'b1) begin
      mon_w.x   = ox;
      mon_w.y   = oy;
      mon_w.ctr = ctr;
      for (int i = 0; i < 16; i++) mon_w.crc[i] = crc[i];
      cap_q.push_back(mon_w);
      cap_e.push_back(edges);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pixval(int px, int py);
    return 8'(px + 16 * py);
  endfunction

  function automatic win_t model(int cx, int cy);
    win_t m;
    m.x   = 4'(cx);
    m.y   = 4'(cy);
    m.ctr = pixval(cx, cy);
    for (int i = 0; i < 16; i++) m.crc[i] = pixval(cx + tdx[i], cy + tdy[i]);
    return m;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    cap_q.delete();
    cap_e.delete();
    exp_q.delete();
    exp_e.delete();
  endtask

  // One accepted pixel, optionally preceded by random idle cycles whose
  // pix/sof contents must be ignored by the DUT.
  task automatic drive(input int bx, input int by, input logic s, input int gap_pct);
    @(posedge clk);
    #1;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      v   = 1'b0;
      sof = 1'($urandom_range(1));
      pix = 8'($urandom_range(255));
      @(posedge clk);
      #1;
    end
    v   = 1'b1;
    sof = s;
    pix = pixval(bx, by);
    if (bx >= 6 && by >= 6) begin
      exp_q.push_back(model(bx - 3, by - 3));
      exp_e.push_back(edges + 2);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    v   = 1'b0;
    sof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stream_frame(input logic s, input int gap_pct);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        drive(xx, yy, (xx == 0 && yy == 0) ? s : 1'b0, gap_pct);
  endtask

  task automatic compare_all(input string label);
    check({label, " count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s win%0d", label, i), cap_q[i], exp_q[i]);
      check($sformatf("%s lat%0d", label, i), cap_e[i], exp_e[i]);
    end
  endtask

  task automatic check_zero(input string label);
    @(negedge clk);
    check({label, " o_v"}, ov, 0);
    check({label, " o_ctr"}, ctr, 0);
    check({label, " o_x"}, ox, 0);
    check({label, " o_y"}, oy, 0);
    for (int i = 0; i < 16; i++) check($sformatf("%s o_crc%0d", label, i), crc[i], 0);
  endtask

  initial begin
    tbl[0] = '{idx: 0,  ex: 3,  ey: 3, ectr: 51,  c0: 3,  c4: 54,  c8: 99,  c12: 48,  c2: 21};
    tbl[1] = '{idx: 9,  ex: 12, ey: 3, ectr: 60,  c0: 12, c4: 63,  c8: 108, c12: 57,  c2: 30};
    tbl[2] = '{idx: 10, ex: 3,  ey: 4, ectr: 67,  c0: 19, c4: 70,  c8: 115, c12: 64,  c2: 37};
    tbl[3] = '{idx: 59, ex: 12, ey: 8, ectr: 140, c0: 92, c4: 143, c8: 188, c12: 137, c2: 110};

    rst = 1'b1;
    v   = 1'b0;
    sof = 1'b0;
    pix = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    // Continuous frame, sof on the very first pixel
    clear_q();
    stream_frame(1'b1, 0);
    idle(4);
    compare_all("cont");
    check("cont total", cap_q.size(), 60);
    ref_q = cap_q;
    for (int t = 0; t < 4; t++) begin
      if (tbl[t].idx < cap_q.size()) begin
        check($sformatf("tbl%0d o_x", t),    cap_q[tbl[t].idx].x,      tbl[t].ex);
        check($sformatf("tbl%0d o_y", t),    cap_q[tbl[t].idx].y,      tbl[t].ey);
        check($sformatf("tbl%0d o_ctr", t),  cap_q[tbl[t].idx].ctr,    tbl[t].ectr);
        check($sformatf("tbl%0d crc0", t),   cap_q[tbl[t].idx].crc[0], tbl[t].c0);
        check($sformatf("tbl%0d crc4", t),   cap_q[tbl[t].idx].crc[4], tbl[t].c4);
        check($sformatf("tbl%0d crc8", t),   cap_q[tbl[t].idx].crc[8], tbl[t].c8);
        check($sformatf("tbl%0d crc12", t),  cap_q[tbl[t].idx].crc[12], tbl[t].c12);
        check($sformatf("tbl%0d crc2", t),   cap_q[tbl[t].idx].crc[2], tbl[t].c2);
      end else begin
        check($sformatf("tbl%0d present", t), cap_q.size(), tbl[t].idx + 1);
      end
    end

    // Same frame with roughly half the cycles idle
    clear_q();
    stream_frame(1'b0, 50);
    idle(4);
    compare_all("gap");
    check("gap total", cap_q.size(), 60);
    for (int i = 0; i < cap_q.size() && i < ref_q.size(); i++)
      check($sformatf("gap vs cont %0d", i), cap_q[i], ref_q[i]);

    // Two frames back to back relying on counter wrap only
    clear_q();
    stream_frame(1'b0, 0);
    stream_frame(1'b0, 0);
    idle(4);
    compare_all("b2b");
    check("b2b total", cap_q.size(), 120);
    if (cap_q.size() > 60) check("b2b frame2 first", cap_q[60], ref_q[0]);

    // Reset in the middle of a frame at pixel (5,7)
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < W; xx++)
        if (yy < 7 || xx <= 5) drive(xx, yy, 1'b0, 0);
    idle(4);
    clear_q();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("midrst");
    stream_frame(1'b0, 0);
    idle(4);
    compare_all("rst");
    check("rst total", cap_q.size(), 60);
    if (cap_q.size() > 0) check("rst first", cap_q[0], ref_q[0]);

    // sof arriving where the DUT thinks it is at (9,4)
    for (int yy = 0; yy < 5; yy++)
      for (int xx = 0; xx < W; xx++)
        if (yy < 4 || xx <= 8) drive(xx, yy, 1'b0, 0);
    idle(2);
    clear_q();
    stream_frame(1'b1, 0);
    idle(4);
    compare_all("sof");
    check("sof total", cap_q.size(), 60);
    if (cap_q.size() > 0) begin
      check("sof first x", cap_q[0].x, 3);
      check("sof first y", cap_q[0].y, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
